// File: rtl/sram_arb_pkg.sv
// Shared constants for the SRAM port arbiter: FSM encoding, HSIZE codes and
// the default WAIT-state limit used when SRAM_PORT_ARB_TIMEOUT_EN is defined.
package sram_arb_pkg;

  localparam logic [1:0] IDLE  = 2'b00;
  localparam logic [1:0] ISSUE = 2'b01;
  localparam logic [1:0] WAIT  = 2'b10;
  localparam logic [1:0] RESP  = 2'b11;

  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;

  localparam int DEF_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// Requester-side and SRAM-controller-side signals of the arbiter; master is the
// arbiter's view, slave is the view of the surrounding requesters and controller.
interface sram_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int AHB_DWIDTH = 32,
  parameter int ADDR_W     = 20
);
  logic [NUM_REQ-1:0]            m_req;
  logic [NUM_REQ-1:0]            m_write;
  logic [3*NUM_REQ-1:0]          m_size;
  logic [ADDR_W*NUM_REQ-1:0]     m_addr;
  logic [AHB_DWIDTH*NUM_REQ-1:0] m_wdata;
  logic [NUM_REQ-1:0]            m_ack;
  logic [AHB_DWIDTH-1:0]         m_rdata;
  logic                          m_err;
  logic                          ahbsram_req;
  logic                          ahbsram_write;
  logic [2:0]                    ahbsram_size;
  logic [ADDR_W-1:0]             ahbsram_addr;
  logic [AHB_DWIDTH-1:0]         ahbsram_wdata;
  logic                          sramahb_ack;
  logic [AHB_DWIDTH-1:0]         sramahb_rdata;
  logic                          BUSY;

  modport master (
    input  m_req, m_write, m_size, m_addr, m_wdata, sramahb_ack, sramahb_rdata, BUSY,
    output m_ack, m_rdata, m_err, ahbsram_req, ahbsram_write, ahbsram_size,
           ahbsram_addr, ahbsram_wdata
  );

  modport slave (
    output m_req, m_write, m_size, m_addr, m_wdata, sramahb_ack, sramahb_rdata, BUSY,
    input  m_ack, m_rdata, m_err, ahbsram_req, ahbsram_write, ahbsram_size,
           ahbsram_addr, ahbsram_wdata
  );
endinterface

// File: rtl/sram_rr_pick.sv
// Combinational round-robin picker: first active request found searching
// upward from ptr+1, wrapping modulo NUM_REQ.
module sram_rr_pick #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Round-robin arbiter sharing one SRAM controller port between NUM_REQ requesters.
// Define SRAM_PORT_ARB_TIMEOUT_EN to bound the WAIT state and flag m_err.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int AHB_DWIDTH     = 32,
  parameter int ADDR_W         = 20,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic                 HCLK,
  input logic                 HRESET,
  sram_port_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 2) ? 2 : 1;

  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 15) begin : g_bad_param
    $error("sram_port_arbiter: NUM_REQ must be 2..4 and TIMEOUT_CYCLES 1..15");
  end

  logic [1:0]            state;
  logic [IDX_W-1:0]      ptr;
  logic [IDX_W-1:0]      idx;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]    pick_grant;
  logic                  wr_q;
  logic [2:0]            size_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [AHB_DWIDTH-1:0] wdata_q;
  logic                  to_hit;
  logic                  timed_out;

  sram_rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
    .req   (bus.m_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state   <= IDLE;
      ptr     <= IDX_W'(NUM_REQ - 1);
      idx     <= '0;
      grant   <= '0;
      wr_q    <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      case (state)
        IDLE: if (|bus.m_req && !bus.BUSY) begin
          idx     <= pick_idx;
          grant   <= pick_grant;
          wr_q    <= bus.m_write[pick_idx];
          size_q  <= bus.m_size[int'(pick_idx)*3 +: 3];
          addr_q  <= bus.m_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
          wdata_q <= bus.m_wdata[int'(pick_idx)*AHB_DWIDTH +: AHB_DWIDTH];
          state   <= ISSUE;
        end
        ISSUE: state <= WAIT;
        WAIT:  if (bus.sramahb_ack || to_hit) state <= RESP;
        default: begin
          ptr   <= idx;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef SRAM_PORT_ARB_TIMEOUT_EN
  // Counter covers WAIT cycles only; a real ack on the last cycle still wins.
  logic [3:0] to_cnt;

  assign to_hit = (state == WAIT) && !bus.sramahb_ack && (to_cnt == 4'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else if (state == ISSUE) begin
      to_cnt    <= '0;
      timed_out <= 1'b0;
    end else if (to_hit) begin
      timed_out <= 1'b1;
    end else if (state == WAIT) begin
      to_cnt <= to_cnt + 4'd1;
    end
  end

  assign bus.m_err = (state == RESP) && timed_out;
`else
  assign to_hit    = 1'b0;
  assign timed_out = 1'b0;
  assign bus.m_err = 1'b0;
`endif

  assign bus.ahbsram_req   = (state == ISSUE);
  assign bus.ahbsram_write = wr_q;
  assign bus.ahbsram_size  = size_q;
  assign bus.ahbsram_addr  = addr_q;
  assign bus.ahbsram_wdata = wdata_q;
  assign bus.m_ack         = (state == RESP) ? grant : '0;
  assign bus.m_rdata       = (state == RESP && !wr_q && !timed_out) ? bus.sramahb_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a vector table of single accesses plus
// hand-written contention, BUSY, stray-ack, reset-in-WAIT and WAIT-limit sequences.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  logic HCLK = 1'b0;
  logic HRESET;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sram_port_arbiter_if #(.NUM_REQ(2), .AHB_DWIDTH(32), .ADDR_W(20)) bus ();

  sram_port_arbiter #(.NUM_REQ(2), .AHB_DWIDTH(32), .ADDR_W(20), .TIMEOUT_CYCLES(15)) dut (
    .HCLK   (HCLK),
    .HRESET (HRESET),
    .bus    (bus)
  );

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  typedef struct {
    int          req;
    logic        write;
    logic [2:0]  size;
    logic [19:0] addr;
    logic [31:0] wdata;
    logic [31:0] sram_rdata;
    logic [1:0]  exp_ack;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vt[6];

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input logic w, input logic [2:0] sz,
                         input logic [19:0] a, input logic [31:0] wd);
    bus.m_write[i]          = w;
    bus.m_size[i*3 +: 3]    = sz;
    bus.m_addr[i*20 +: 20]  = a;
    bus.m_wdata[i*32 +: 32] = wd;
    bus.m_req[i]            = 1'b1;
  endtask

  // Waits (bounded) for ISSUE, checks the SRAM-side request, acks in WAIT and checks RESP.
  task automatic serve(input int i, input logic [1:0] exp_ack, input logic exp_w,
                       input logic [2:0] exp_sz, input logic [19:0] exp_a,
                       input logic [31:0] exp_wd, input logic [31:0] rd,
                       input logic [31:0] exp_rd, input bit drop_early,
                       input bit drop_after, output int t_issue);
    int n = 0;
    while (bus.ahbsram_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("issue_seen", 64'(bus.ahbsram_req), 64'd1);
    t_issue = cyc;
    check("issue_write", 64'(bus.ahbsram_write), 64'(exp_w));
    check("issue_size", 64'(bus.ahbsram_size), 64'(exp_sz));
    check("issue_addr", 64'(bus.ahbsram_addr), 64'(exp_a));
    check("issue_wdata", 64'(bus.ahbsram_wdata), 64'(exp_wd));
    check("issue_no_ack", 64'(bus.m_ack), 64'd0);
    if (drop_early) bus.m_req[i] = 1'b0;
    tick();
    check("wait_req_low", 64'(bus.ahbsram_req), 64'd0);
    check("wait_addr_hold", 64'(bus.ahbsram_addr), 64'(exp_a));
    bus.sramahb_ack   = 1'b1;
    bus.sramahb_rdata = 32'h0BAD_0BAD;
    tick();
    bus.sramahb_ack   = 1'b0;
    bus.sramahb_rdata = rd;
    #1;
    check("resp_ack", 64'(bus.m_ack), 64'(exp_ack));
    check("resp_rdata", 64'(bus.m_rdata), 64'(exp_rd));
    check("resp_err", 64'(bus.m_err), 64'd0);
    if (drop_after) bus.m_req[i] = 1'b0;
    tick();
    check("idle_ack_low", 64'(bus.m_ack), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t_fall, seen, n;

    vt[0] = '{0, 1'b0, SZ_WORD, 20'h00010, 32'h1111_1111, 32'hDEAD_BEEF, 2'b01, 32'hDEAD_BEEF};
    vt[1] = '{1, 1'b1, SZ_BYTE, 20'h00003, 32'h0000_00A5, 32'h1234_5678, 2'b10, 32'h0000_0000};
    vt[2] = '{1, 1'b0, SZ_HALF, 20'h00ABC, 32'h0000_0000, 32'h0000_CAFE, 2'b10, 32'h0000_CAFE};
    vt[3] = '{0, 1'b1, SZ_WORD, 20'hFFFFC, 32'h5A5A_5A5A, 32'hFFFF_FFFF, 2'b01, 32'h0000_0000};
    vt[4] = '{0, 1'b0, SZ_BYTE, 20'hFFFFF, 32'h0000_0000, 32'h0000_00FF, 2'b01, 32'h0000_00FF};
    vt[5] = '{1, 1'b0, SZ_WORD, 20'h00400, 32'h0000_0000, 32'h8000_0001, 2'b10, 32'h8000_0001};

    HRESET            = 1'b1;
    bus.m_req         = '0;
    bus.m_write       = '0;
    bus.m_size        = '0;
    bus.m_addr        = '0;
    bus.m_wdata       = '0;
    bus.sramahb_ack   = 1'b0;
    bus.sramahb_rdata = '0;
    bus.BUSY          = 1'b0;
    tick();
    tick();
    check("rst_req", 64'(bus.ahbsram_req), 64'd0);
    check("rst_ack", 64'(bus.m_ack), 64'd0);
    check("rst_rdata", 64'(bus.m_rdata), 64'd0);
    check("rst_err", 64'(bus.m_err), 64'd0);
    check("rst_addr", 64'(bus.ahbsram_addr), 64'd0);
    check("rst_wdata", 64'(bus.ahbsram_wdata), 64'd0);
    HRESET = 1'b0;
    tick();

    // Single accesses; m_req drops during ISSUE to confirm latched requests complete.
    for (int v = 0; v < 6; v++) begin
      set_req(vt[v].req, vt[v].write, vt[v].size, vt[v].addr, vt[v].wdata);
      serve(vt[v].req, vt[v].exp_ack, vt[v].write, vt[v].size, vt[v].addr, vt[v].wdata,
            vt[v].sram_rdata, vt[v].exp_rdata, 1'b1, 1'b1, t0);
    end

    // Contention: pointer is at 1, so requester 0 goes first.
    set_req(0, 1'b0, SZ_WORD, 20'h00100, 32'h0);
    set_req(1, 1'b0, SZ_WORD, 20'h00200, 32'h0);
    serve(0, 2'b01, 1'b0, SZ_WORD, 20'h00100, 32'h0, 32'hA0A0_0000, 32'hA0A0_0000, 1'b0, 1'b1, t0);
    serve(1, 2'b10, 1'b0, SZ_WORD, 20'h00200, 32'h0, 32'hB1B1_0001, 32'hB1B1_0001, 1'b0, 1'b1, t1);
    check("rr_spacing_a", 64'(t1 - t0), 64'd4);
    bus.m_req = 2'b11;
    serve(0, 2'b01, 1'b0, SZ_WORD, 20'h00100, 32'h0, 32'h0000_0010, 32'h0000_0010, 1'b0, 1'b0, t0);
    serve(1, 2'b10, 1'b0, SZ_WORD, 20'h00200, 32'h0, 32'h0000_0011, 32'h0000_0011, 1'b0, 1'b0, t1);
    check("rr_spacing_b", 64'(t1 - t0), 64'd4);
    serve(0, 2'b01, 1'b0, SZ_WORD, 20'h00100, 32'h0, 32'h0000_0020, 32'h0000_0020, 1'b0, 1'b1, t0);
    serve(1, 2'b10, 1'b0, SZ_WORD, 20'h00200, 32'h0, 32'h0000_0021, 32'h0000_0021, 1'b0, 1'b1, t1);
    check("rr_spacing_c", 64'(t1 - t0), 64'd4);

    // BUSY holds off the grant for its whole duration.
    bus.BUSY = 1'b1;
    set_req(1, 1'b0, SZ_HALF, 20'h00A00, 32'h0);
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (bus.ahbsram_req === 1'b1) seen++;
    end
    check("busy_no_issue", 64'(seen), 64'd0);
    bus.BUSY = 1'b0;
    t_fall = cyc;
    serve(1, 2'b10, 1'b0, SZ_HALF, 20'h00A00, 32'h0, 32'h0000_7777, 32'h0000_7777, 1'b0, 1'b1, t0);
    check("busy_release", 64'(t0 - t_fall), 64'd1);

    // Stray controller ack while idle.
    bus.sramahb_ack = 1'b1;
    tick();
    bus.sramahb_ack = 1'b0;
    check("stray_req", 64'(bus.ahbsram_req), 64'd0);
    check("stray_ack", 64'(bus.m_ack), 64'd0);
    tick();
    check("stray_ack_next", 64'(bus.m_ack), 64'd0);

    // Reset in WAIT: pointer 0 beforehand, so only a pointer reset lets requester 0 win next.
    set_req(0, 1'b0, SZ_WORD, 20'h00050, 32'h0);
    serve(0, 2'b01, 1'b0, SZ_WORD, 20'h00050, 32'h0, 32'h0000_0050, 32'h0000_0050, 1'b0, 1'b0, t0);
    n = 0;
    while (bus.ahbsram_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("rstw_issue", 64'(bus.ahbsram_req), 64'd1);
    tick();
    HRESET = 1'b1;
    #1;
    check("rstw_req", 64'(bus.ahbsram_req), 64'd0);
    check("rstw_addr", 64'(bus.ahbsram_addr), 64'd0);
    check("rstw_ack", 64'(bus.m_ack), 64'd0);
    bus.m_req       = '0;
    bus.sramahb_ack = 1'b1;
    seen = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (bus.m_ack !== 2'b00) seen++;
    end
    bus.sramahb_ack = 1'b0;
    check("rstw_no_ack", 64'(seen), 64'd0);
    HRESET = 1'b0;
    set_req(0, 1'b0, SZ_WORD, 20'h00111, 32'h0);
    set_req(1, 1'b0, SZ_WORD, 20'h00222, 32'h0);
    serve(0, 2'b01, 1'b0, SZ_WORD, 20'h00111, 32'h0, 32'h0000_0111, 32'h0000_0111, 1'b0, 1'b1, t0);
    serve(1, 2'b10, 1'b0, SZ_WORD, 20'h00222, 32'h0, 32'h0000_0222, 32'h0000_0222, 1'b0, 1'b1, t1);

    // Controller that never acks.
    set_req(0, 1'b0, SZ_WORD, 20'h00040, 32'h0);
    bus.sramahb_rdata = 32'hFFFF_FFFF;
    n = 0;
    while (bus.ahbsram_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check("to_issue", 64'(bus.ahbsram_req), 64'd1);
    t0 = cyc;
    bus.m_req = '0;
`ifdef SRAM_PORT_ARB_TIMEOUT_EN
    n = 0;
    while (bus.m_ack === 2'b00 && n < 40) begin
      tick();
      n++;
    end
    check("to_latency", 64'(cyc - t0), 64'd16);
    check("to_ack", 64'(bus.m_ack), 64'(2'b01));
    check("to_err", 64'(bus.m_err), 64'd1);
    check("to_rdata", 64'(bus.m_rdata), 64'd0);
    tick();
    bus.sramahb_ack = 1'b1;
    tick();
    bus.sramahb_ack = 1'b0;
    check("late_ack_req", 64'(bus.ahbsram_req), 64'd0);
    check("late_ack_ack", 64'(bus.m_ack), 64'd0);
    tick();
    check("late_ack_next", 64'(bus.m_ack), 64'd0);
`else
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (bus.m_ack !== 2'b00) seen++;
    end
    check("nto_still_wait", 64'(seen), 64'd0);
    bus.sramahb_ack = 1'b1;
    tick();
    bus.sramahb_ack   = 1'b0;
    bus.sramahb_rdata = 32'h0000_4040;
    #1;
    check("nto_ack", 64'(bus.m_ack), 64'(2'b01));
    check("nto_err", 64'(bus.m_err), 64'd0);
    check("nto_rdata", 64'(bus.m_rdata), 64'h4040);
    tick();
    check("nto_idle", 64'(bus.m_ack), 64'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Round-robin arbiter that shares one SRAM control interface (req/write/size/addr/wdata in; ack/rdata/BUSY back) between NUM_REQ AHB-side requesters, e.g. a DMA engine and a CPU slave port.
- Serialises single accesses and drives exactly one SRAM request pulse per grant.
- Waits for the SRAM ack, then returns read data plus a one-cycle ack to the granted requester.

Parameters:
- NUM_REQ, 2, number of requesters (legal 2..4).
- AHB_DWIDTH, 32, data width.
- ADDR_W, 20, byte-address width.
- TIMEOUT_CYCLES, 15, WAIT-state cycle limit (used only with the optional feature).

Ports:
- HCLK  in  1  clock.
- HRESET  in  1  reset; asynchronous assert, active-high.
- m_req  in  NUM_REQ  per-requester level request; held until that requester's m_ack.
- m_write  in  NUM_REQ  1 = write.
- m_size  in  3*NUM_REQ  HSIZE (000 byte, 001 half, 010 word).
- m_addr  in  ADDR_W*NUM_REQ  byte address.
- m_wdata  in  AHB_DWIDTH*NUM_REQ  write data.
- m_ack  out  NUM_REQ  one-cycle completion pulse, one-hot.
- m_rdata  out  AHB_DWIDTH  read data, valid when any m_ack is high.
- m_err  out  1  timeout flag, qualified by m_ack (always 0 without the optional feature).
- ahbsram_req  out  1  one-cycle request to the SRAM controller.
- ahbsram_write  out  1  registered.
- ahbsram_size  out  3  registered.
- ahbsram_addr  out  ADDR_W  registered.
- ahbsram_wdata  out  AHB_DWIDTH  registered.
- sramahb_ack  in  1  SRAM completion pulse.
- sramahb_rdata  in  AHB_DWIDTH  SRAM read data; valid the cycle after sramahb_ack.
- BUSY  in  1  SRAM busy; no new issue while high.

Behaviour:
- Reset values: state IDLE, rr pointer = NUM_REQ-1 (requester 0 wins first), all outputs 0.
- Reset asserted mid-transaction aborts it silently: no m_ack is issued.
- States:
  - IDLE: if any m_req and BUSY=0, pick a winner with round-robin, searching from pointer+1 modulo NUM_REQ. Latch its index, write, size, addr and wdata into the ahbsram_* registers, then go to ISSUE. Otherwise stay in IDLE.
  - ISSUE: ahbsram_req = 1 for exactly one cycle; go to WAIT.
  - WAIT: on sramahb_ack go to RESP. ahbsram_req stays 0 and the address/data registers hold.
  - RESP: m_ack[idx] = 1; m_rdata = sramahb_rdata for reads, 0 for writes. Set pointer = idx and go to IDLE.
- Latency: m_req sampled in IDLE at cycle T → ISSUE at T+1 → controller ack at T+2 → m_ack at T+3. Peak rate is one access per 4 cycles.
- Requesters deassert m_req the cycle after m_ack. A req still high in the following IDLE cycle is a new request.
- Dropping m_req before it is granted is legal and ignored. Once a request is latched it always completes, even if m_req drops.
- BUSY rising while in ISSUE or WAIT has no effect; BUSY gates only the IDLE decision.
- sramahb_ack arriving while not in WAIT is ignored. No arbiter output changes on it.
- Simultaneous requests from all requesters are served strictly in rotation; no requester waits more than NUM_REQ-1 grants.
- m_ack is never asserted for two requesters in the same cycle.

Optional Feature:
- Macro: SRAM_PORT_ARB_TIMEOUT_EN.
- Defined: a 4-bit counter clears on entry to WAIT and increments each WAIT cycle. If it reaches TIMEOUT_CYCLES without sramahb_ack, go to RESP with m_err = 1 and m_rdata = 0.
- A late sramahb_ack after a timeout is ignored.
- Undefined: no counter; m_err is tied to 0; WAIT waits indefinitely.

Decomposition:
- Package sram_arb_pkg holds:
  - state encoding constants: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, RESP=2'b11;
  - HSIZE constants: SZ_BYTE, SZ_HALF, SZ_WORD;
  - default TIMEOUT_CYCLES.
- One combinational sub-module, sram_rr_pick: inputs are the request vector and pointer; outputs are a one-hot grant and its index.
- FSM, latches and timeout logic stay in the top module.

Test Plan:
- Single read: m_req[0] = 1, addr 0x00010, with the SRAM model returning 0xDEADBEEF. Expect one ahbsram_req pulse with addr 0x00010, write 0. Expect m_ack[0] 3 cycles after the req is sampled, with m_rdata 0xDEADBEEF.
- Contention: m_req = 2'b11 held, then each requester drops its req after its ack. Expect grant order 0, 1. Then requester 0 re-requests: expect grant order 0, 1, 0, 1 with no back-to-back repeats; the second grant's ISSUE comes 4 cycles after the first's.
- BUSY: BUSY = 1 for 10 cycles with m_req[1] = 1. Expect no ahbsram_req until the cycle after BUSY falls, then normal completion.
- Byte write: m_req[1], write = 1, size = 000, addr 0x00003, wdata 0x000000A5. Expect the ahbsram_* outputs to match exactly during ISSUE, and m_ack[1] with m_rdata 0.
- Reset in WAIT: assert HRESET while in WAIT. Expect all outputs 0 immediately, no m_ack, and a fresh request after reset to go to requester 0.
- Timeout (macro defined): the SRAM model never acks. Expect m_ack with m_err = 1 after 15 WAIT cycles, and a later stray sramahb_ack to be ignored.
